uart_tx_param: RTL and testbench



---
 rtl/uart_tx_param.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param
// Parametrised UART transmitter. It takes words over a valid/ready handshake
// and sends them on an idle-high serial line. Each frame is a start bit, then
// DATA_BITS data bits LSB first, then an optional parity bit, then STOP_BITS
// stop bits. Each bit lasts CLK_DIV clk cycles. Frames can run back to back
// with no idle cycle between them.
//
// Parameters:
//   CLK_DIV    clk cycles per serial bit (2..65535)
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   tx_data     in   word to send; sampled only on handshake
//   tx_valid    in   source has a word
//   tx_ready    out  block can accept a word this cycle
//   tx          out  registered serial line, idle high
//   busy        out  high while a frame is on the line
//   frame_done  out  one-cycle pulse in the final cycle of the last stop bit
module uart_tx_param #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   parity_q, parity_d;
  logic                   tx_q, tx_d;

  logic bit_end;
  logic last_data;
  logic last_stop;
  logic handshake;

  // A bit boundary is the last cycle of the baud count.
  assign bit_end   = (cnt_q == CW'(CLK_DIV - 1));
  assign last_data = (bit_cnt_q == 4'(DATA_BITS - 1));
  assign last_stop = (bit_cnt_q == 4'(STOP_BITS - 1));

  // Ready in the final stop-bit cycle lets the next START follow with no gap.
  assign tx_ready   = (state_q == ST_IDLE) ||
                      (state_q == ST_STOP && bit_end && last_stop);
  assign handshake  = tx_valid && tx_ready;
  assign frame_done = (state_q == ST_STOP) && bit_end && last_stop;
  assign busy       = (state_q != ST_IDLE);
  assign tx         = tx_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    parity_d  = parity_q;
    tx_d      = 1'b1;

    if (state_q != ST_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: ;
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (last_data) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A handshake restarts the baud count so bit timing follows the word,
    // whether it arrives in IDLE or in the last stop-bit cycle.
    if (handshake) begin
      state_d  = ST_START;
      cnt_d    = '0;
      shreg_d  = tx_data;
      parity_d = (PARITY == 1) ? ~^tx_data : ^tx_data;
    end

    // The line value is computed for the coming cycle so tx can be a flop.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param
// Directed bench for uart_tx_param. Four instances share clk and reset_n:
//   dut_a  CLK_DIV=4, 8 data bits, no parity, 1 stop
//   dut_e  CLK_DIV=4, 8 data bits, even parity, 2 stop
//   dut_o  CLK_DIV=4, 8 data bits, odd parity, 2 stop
//   dut_f  CLK_DIV=4, 5 data bits, no parity, 1 stop
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// The j-th falling edge after handshake edge k lies in frame cycle k+j.
module tb_uart_tx_param;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [7:0] a_data = '0, e_data = '0, o_data = '0;
  logic [4:0] f_data = '0;
  logic a_valid = 0, e_valid = 0, o_valid = 0, f_valid = 0;
  logic a_ready, e_ready, o_ready, f_ready;
  logic a_tx, e_tx, o_tx, f_tx;
  logic a_busy, e_busy, o_busy, f_busy;
  logic a_done, e_done, o_done, f_done;

  int hs_a = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (reset_n && a_valid && a_ready) hs_a <= hs_a + 1;

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .tx(a_tx), .busy(a_busy), .frame_done(a_done));

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_e (
    .clk(clk), .reset_n(reset_n), .tx_data(e_data), .tx_valid(e_valid),
    .tx_ready(e_ready), .tx(e_tx), .busy(e_busy), .frame_done(e_done));

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut_o (
    .clk(clk), .reset_n(reset_n), .tx_data(o_data), .tx_valid(o_valid),
    .tx_ready(o_ready), .tx(o_tx), .busy(o_busy), .frame_done(o_done));

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) dut_f (
    .clk(clk), .reset_n(reset_n), .tx_data(f_data), .tx_valid(f_valid),
    .tx_ready(f_ready), .tx(f_tx), .busy(f_busy), .frame_done(f_done));

  task automatic test_reset;
    logic [3:0] exp_line;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({a_tx, a_busy, a_ready, a_done} !== 4'b1010) begin
      bad++;
      $display("FAIL reset_state: {tx,busy,ready,done} got %b expected 1010",
               {a_tx, a_busy, a_ready, a_done});
    end
    reset_n = 1'b1;
    exp_line = 4'b1111;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      total++;
      if ({a_tx, a_busy, a_ready} !== 3'b101) begin
        bad++;
        $display("FAIL idle_a cycle %0d: {tx,busy,ready} got %b expected 101",
                 i, {a_tx, a_busy, a_ready});
      end
      total++;
      if ({a_tx, e_tx, o_tx, f_tx} !== exp_line ||
          {a_done, e_done, o_done, f_done} !== 4'b0000) begin
        bad++;
        $display("FAIL idle_all cycle %0d: tx %b done %b expected tx 1111 done 0000",
                 i, {a_tx, e_tx, o_tx, f_tx}, {a_done, e_done, o_done, f_done});
      end
    end
  endtask

  task automatic test_8n1;
    // 0x55: start 0, data 1,0,1,0,1,0,1,0, stop 1 (index 0 = start)
    logic [9:0] exp_bits = 10'b1010101010;
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("FAIL 8n1_ready: got %b expected 1", a_ready);
    end
    a_data = 8'h55; a_valid = 1'b1;
    @(posedge clk); #1 a_valid = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      total++;
      if ({a_tx, a_busy, a_done} !== {exp_bits[(j-1)/4], 1'b1, (j == 40)}) begin
        bad++;
        $display("FAIL 8n1 cycle %0d: {tx,busy,done} got %b expected %b",
                 j, {a_tx, a_busy, a_done}, {exp_bits[(j-1)/4], 1'b1, (j == 40)});
      end
    end
    @(negedge clk);
    total++;
    if ({a_tx, a_busy, a_ready, a_done} !== 4'b1010) begin
      bad++;
      $display("FAIL 8n1_after: {tx,busy,ready,done} got %b expected 1010",
               {a_tx, a_busy, a_ready, a_done});
    end
  endtask

  task automatic test_parity;
    // 0x07: start 0, data 1,1,1,0,0,0,0,0, parity, stop 1,1
    logic [11:0] exp_even = 12'b1110_0000_1110;
    logic [11:0] exp_odd  = 12'b1100_0000_1110;
    e_data = 8'h07; o_data = 8'h07; e_valid = 1'b1; o_valid = 1'b1;
    @(posedge clk); #1 e_valid = 1'b0; o_valid = 1'b0;
    for (int j = 1; j <= 48; j++) begin
      @(negedge clk);
      total++;
      if ({e_tx, e_busy, e_done} !== {exp_even[(j-1)/4], 1'b1, (j == 48)}) begin
        bad++;
        $display("FAIL even_parity cycle %0d: {tx,busy,done} got %b expected %b",
                 j, {e_tx, e_busy, e_done}, {exp_even[(j-1)/4], 1'b1, (j == 48)});
      end
      total++;
      if ({o_tx, o_busy, o_done} !== {exp_odd[(j-1)/4], 1'b1, (j == 48)}) begin
        bad++;
        $display("FAIL odd_parity cycle %0d: {tx,busy,done} got %b expected %b",
                 j, {o_tx, o_busy, o_done}, {exp_odd[(j-1)/4], 1'b1, (j == 48)});
      end
    end
    @(negedge clk);
    total++;
    if ({e_busy, o_busy, e_tx, o_tx} !== 4'b0011) begin
      bad++;
      $display("FAIL parity_after: {e_busy,o_busy,e_tx,o_tx} got %b expected 0011",
               {e_busy, o_busy, e_tx, o_tx});
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp1 = 10'b1101001010;  // 0xA5
    logic [9:0] exp2 = 10'b1001111000;  // 0x3C
    logic [3:0] exp_v;
    int hs0;
    hs0 = hs_a;
    a_data = 8'hA5; a_valid = 1'b1;
    @(posedge clk); #1 a_data = 8'h3C;
    for (int j = 1; j <= 80; j++) begin
      @(negedge clk);
      if (j == 41) a_valid = 1'b0;
      exp_v = {(j <= 40) ? exp1[(j-1)/4] : exp2[(j-41)/4], 1'b1,
               (j % 40 == 0), (j % 40 == 0)};
      total++;
      if ({a_tx, a_busy, a_done, a_ready} !== exp_v) begin
        bad++;
        $display("FAIL b2b cycle %0d: {tx,busy,done,ready} got %b expected %b",
                 j, {a_tx, a_busy, a_done, a_ready}, exp_v);
      end
    end
    @(negedge clk);
    total++;
    if ({a_tx, a_busy} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_after: {tx,busy} got %b expected 10", {a_tx, a_busy});
    end
    total++;
    if (hs_a - hs0 !== 2) begin
      bad++;
      $display("FAIL b2b_handshakes: got %0d expected 2", hs_a - hs0);
    end
  endtask

  task automatic test_ignore_busy;
    logic [9:0] exp_bits = 10'b1000011110;  // 0x0F
    int hs0;
    hs0 = hs_a;
    a_data = 8'h0F; a_valid = 1'b1;
    @(posedge clk); #1 a_valid = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j == 10) begin a_data = 8'hFF; a_valid = 1'b1; end
      if (j == 13) a_valid = 1'b0;
      total++;
      if ({a_tx, a_busy, a_done} !== {exp_bits[(j-1)/4], 1'b1, (j == 40)}) begin
        bad++;
        $display("FAIL ignore cycle %0d: {tx,busy,done} got %b expected %b",
                 j, {a_tx, a_busy, a_done}, {exp_bits[(j-1)/4], 1'b1, (j == 40)});
      end
    end
    repeat (2) @(negedge clk);
    total++;
    if ({a_tx, a_busy} !== 2'b10) begin
      bad++;
      $display("FAIL ignore_after: {tx,busy} got %b expected 10", {a_tx, a_busy});
    end
    total++;
    if (hs_a - hs0 !== 1) begin
      bad++;
      $display("FAIL ignore_handshakes: got %0d expected 1", hs_a - hs0);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] w = 8'h81;
    logic [6:0] exp_bits = 7'b1000010;  // 5-bit word 0x01
    a_data = 8'h00; a_valid = 1'b1;
    @(posedge clk); #1 a_valid = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if ({a_tx, a_busy} !== 2'b01) begin
      bad++;
      $display("FAIL mid_data: {tx,busy} got %b expected 01", {a_tx, a_busy});
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({a_tx, a_busy, a_done} !== 3'b100) begin
      bad++;
      $display("FAIL async_reset: {tx,busy,done} got %b expected 100",
               {a_tx, a_busy, a_done});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if ({a_tx, a_busy, a_ready} !== 3'b101) begin
      bad++;
      $display("FAIL post_reset: {tx,busy,ready} got %b expected 101",
               {a_tx, a_busy, a_ready});
    end
    f_data = w[4:0]; f_valid = 1'b1;
    @(posedge clk); #1 f_valid = 1'b0;
    for (int j = 1; j <= 28; j++) begin
      @(negedge clk);
      total++;
      if ({f_tx, f_busy, f_done} !== {exp_bits[(j-1)/4], 1'b1, (j == 28)}) begin
        bad++;
        $display("FAIL five_bit cycle %0d: {tx,busy,done} got %b expected %b",
                 j, {f_tx, f_busy, f_done}, {exp_bits[(j-1)/4], 1'b1, (j == 28)});
      end
    end
    @(negedge clk);
    total++;
    if ({f_tx, f_busy, f_ready} !== 3'b101) begin
      bad++;
      $display("FAIL five_bit_after: {tx,busy,ready} got %b expected 101",
               {f_tx, f_busy, f_ready});
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
